// File: rtl/pcs_pkg.sv
// Shared definitions for the 10GBASE-R transmit path: sequencer states,
// idle control code and the encoder's block-type field values.
package pcs_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_TERM0 = 2'd2
    } pcs_tx_state_t;

    localparam logic [6:0] CTRL_IDLE = 7'h00;

    localparam logic [7:0] BT_IDLE   = 8'h1E;
    localparam logic [7:0] BT_START0 = 8'h78;
    localparam logic [7:0] BT_TERM0  = 8'h87;
    localparam logic [7:0] BT_TERM1  = 8'h99;
    localparam logic [7:0] BT_TERM2  = 8'hAA;
    localparam logic [7:0] BT_TERM3  = 8'hB4;
    localparam logic [7:0] BT_TERM4  = 8'hCC;
    localparam logic [7:0] BT_TERM5  = 8'hD2;
    localparam logic [7:0] BT_TERM6  = 8'hE1;
    localparam logic [7:0] BT_TERM7  = 8'hFF;

    // Block-type byte the encoder selects for a given set of control flags/keep.
    function automatic logic [7:0] blk_type(input logic       idle_v,
                                            input logic       start_v,
                                            input logic       term_v,
                                            input logic [7:0] keep);
        logic [7:0] bt;
        bt = 8'h00;
        if (idle_v) begin
            bt = BT_IDLE;
        end else if (start_v) begin
            bt = BT_START0;
        end else if (term_v) begin
            case (keep)
                8'h01:   bt = BT_TERM1;
                8'h03:   bt = BT_TERM2;
                8'h07:   bt = BT_TERM3;
                8'h0F:   bt = BT_TERM4;
                8'h1F:   bt = BT_TERM5;
                8'h3F:   bt = BT_TERM6;
                8'h7F:   bt = BT_TERM7;
                default: bt = BT_TERM0;
            endcase
        end
        return bt;
    endfunction

endpackage

// File: rtl/pcs_tx_term_align.sv
// Terminate payload alignment: shift the last beat up one byte (slot 0 is
// the block-type field) and clear every byte beyond the last valid one.
module pcs_tx_term_align #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned KEEP_W = DATA_W / 8
) (
    input  logic [KEEP_W-1:0] keep_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o
);

    // The top byte and top keep bit can never land inside a terminate block.
    logic unused_top_bits;
    assign unused_top_bits = ^{keep_i[KEEP_W-1], data_i[DATA_W-1 -: 8]};

    always_comb begin
        data_o = '0;
        for (int i = 1; i < int'(KEEP_W); i++) begin
            if (keep_i[i-1]) begin
                data_o[8*i +: 8] = data_i[8*(i-1) +: 8];
            end
        end
    end

endmodule

// File: rtl/pcs_tx_ctrl.sv
// MAC-to-PCS transmit sequencer: frames MAC beats into start/data/terminate
// blocks, fills gaps with idles, enforces the IPG and follows gearbox stalls.
module pcs_tx_ctrl
    import pcs_pkg::*;
#(
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned KEEP_W  = DATA_W / 8,
    parameter int unsigned IPG_BLK = 1,
    parameter int unsigned CNT_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_valid_i,
    output logic              s_ready_o,
    input  logic [DATA_W-1:0] s_data_i,
    input  logic [KEEP_W-1:0] s_keep_i,
    input  logic              s_last_i,
    input  logic              gb_ready_i,
    output logic              enc_ctrl_v_o,
    output logic              enc_idle_v_o,
    output logic              enc_start_v_o,
    output logic              enc_term_v_o,
    output logic              enc_err_v_o,
    output logic [DATA_W-1:0] enc_data_o,
    output logic [KEEP_W-1:0] enc_keep_o,
    output logic              underrun_o
);

    localparam logic [DATA_W-1:0] IDLE_DATA = {KEEP_W{1'b0, CTRL_IDLE}};
    localparam logic [KEEP_W-1:0] KEEP_ALL  = {KEEP_W{1'b1}};
    localparam logic [CNT_W-1:0]  IPG_LOAD  = CNT_W'(IPG_BLK);

    pcs_tx_state_t     state_q, state_d;
    logic [CNT_W-1:0]  ipg_q, ipg_d;
    logic              ctrl_q, ctrl_d, idle_q, idle_d, start_q, start_d;
    logic              term_q, term_d, err_q, err_d, underrun_q, underrun_d;
    logic [DATA_W-1:0] data_q, data_d, term_data_c;
    logic [KEEP_W-1:0] keep_q, keep_d;
    logic              accept_c;

    pcs_tx_term_align #(
        .DATA_W (DATA_W),
        .KEEP_W (KEEP_W)
    ) u_term_align (
        .keep_i (s_keep_i),
        .data_i (s_data_i),
        .data_o (term_data_c)
    );

    assign s_ready_o = ~reset & gb_ready_i &
                       (((state_q == ST_IDLE) && (ipg_q == '0)) || (state_q == ST_DATA));
    assign accept_c  = s_valid_i & s_ready_o;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ipg_q      <= '0;
            ctrl_q     <= 1'b1;
            idle_q     <= 1'b1;
            start_q    <= 1'b0;
            term_q     <= 1'b0;
            err_q      <= 1'b0;
            data_q     <= '0;
            keep_q     <= '0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ipg_q      <= ipg_d;
            ctrl_q     <= ctrl_d;
            idle_q     <= idle_d;
            start_q    <= start_d;
            term_q     <= term_d;
            err_q      <= err_d;
            data_q     <= data_d;
            keep_q     <= keep_d;
            underrun_q <= underrun_d;
        end
    end

    // Next block selection; everything except the underrun pulse holds while stalled.
    always_comb begin
        state_d    = state_q;
        ipg_d      = ipg_q;
        ctrl_d     = ctrl_q;
        idle_d     = idle_q;
        start_d    = start_q;
        term_d     = term_q;
        err_d      = err_q;
        data_d     = data_q;
        keep_d     = keep_q;
        underrun_d = 1'b0;

        if (gb_ready_i) begin
            ctrl_d  = 1'b1;
            idle_d  = 1'b0;
            start_d = 1'b0;
            term_d  = 1'b0;
            err_d   = 1'b0;
            data_d  = '0;
            keep_d  = '0;
            unique case (state_q)
                ST_IDLE: begin
                    if (accept_c) begin
                        start_d = 1'b1;
                        data_d  = s_data_i;
                        keep_d  = KEEP_ALL;
                        state_d = s_last_i ? ST_TERM0 : ST_DATA;
                    end else begin
                        idle_d = 1'b1;
                        data_d = IDLE_DATA;
                        if (ipg_q != '0) begin
                            ipg_d = ipg_q - CNT_W'(1);
                        end
                    end
                end
                ST_DATA: begin
                    if (!s_valid_i) begin
                        term_d     = 1'b1;
                        err_d      = 1'b1;
                        underrun_d = 1'b1;
                        ipg_d      = IPG_LOAD;
                        state_d    = ST_IDLE;
                    end else if (!s_last_i || (s_keep_i == KEEP_ALL)) begin
                        ctrl_d = 1'b0;
                        data_d = s_data_i;
                        keep_d = KEEP_ALL;
                        if (s_last_i) begin
                            state_d = ST_TERM0;
                        end
                    end else begin
                        term_d  = 1'b1;
                        data_d  = term_data_c;
                        keep_d  = s_keep_i;
                        ipg_d   = IPG_LOAD;
                        state_d = ST_IDLE;
                    end
                end
                ST_TERM0: begin
                    term_d  = 1'b1;
                    ipg_d   = IPG_LOAD;
                    state_d = ST_IDLE;
                end
                default: begin
                    idle_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign enc_ctrl_v_o  = ctrl_q;
    assign enc_idle_v_o  = idle_q;
    assign enc_start_v_o = start_q;
    assign enc_term_v_o  = term_q;
    assign enc_err_v_o   = err_q;
    assign enc_data_o    = data_q;
    assign enc_keep_o    = keep_q;
    assign underrun_o    = underrun_q;

endmodule

// File: tb/tb_pcs_tx_ctrl.sv
// Directed self-checking bench for pcs_tx_ctrl with a 3-block inter-packet gap.
module tb_pcs_tx_ctrl;

    localparam int unsigned DATA_W  = 64;
    localparam int unsigned KEEP_W  = 8;
    localparam int unsigned IPG_BLK = 3;

    localparam logic [4:0] F_IDLE  = 5'b11000;
    localparam logic [4:0] F_START = 5'b10100;
    localparam logic [4:0] F_DATA  = 5'b00000;
    localparam logic [4:0] F_TERM  = 5'b10010;
    localparam logic [4:0] F_ERR   = 5'b10011;

    logic              clk = 1'b0;
    logic              reset;
    logic              s_valid, s_ready, s_last, gb_ready;
    logic [DATA_W-1:0] s_data;
    logic [KEEP_W-1:0] s_keep;
    logic              ctrl_v, idle_v, start_v, term_v, err_v, underrun;
    logic [DATA_W-1:0] enc_data;
    logic [KEEP_W-1:0] enc_keep;
    logic [76:0]       blk;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign blk = {ctrl_v, idle_v, start_v, term_v, err_v, enc_keep, enc_data};

    pcs_tx_ctrl #(
        .DATA_W  (DATA_W),
        .KEEP_W  (KEEP_W),
        .IPG_BLK (IPG_BLK),
        .CNT_W   (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .s_valid_i     (s_valid),
        .s_ready_o     (s_ready),
        .s_data_i      (s_data),
        .s_keep_i      (s_keep),
        .s_last_i      (s_last),
        .gb_ready_i    (gb_ready),
        .enc_ctrl_v_o  (ctrl_v),
        .enc_idle_v_o  (idle_v),
        .enc_start_v_o (start_v),
        .enc_term_v_o  (term_v),
        .enc_err_v_o   (err_v),
        .enc_data_o    (enc_data),
        .enc_keep_o    (enc_keep),
        .underrun_o    (underrun)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [63:0] d, input logic [7:0] k, input logic l);
        s_valid = 1'b1;
        s_data  = d;
        s_keep  = k;
        s_last  = l;
    endtask

    task automatic test_reset();
        logic [76:0] exp;
        reset = 1'b1; gb_ready = 1'b1; s_valid = 1'b0;
        s_data = '0; s_keep = '0; s_last = 1'b0;
        tick(); tick();
        exp = {F_IDLE, 8'h00, 64'h0};
        n_cmp++;
        if (blk !== exp) begin
            n_err++; $display("FAIL reset_blk got=%h exp=%h", blk, exp);
        end
        n_cmp++;
        if ({s_ready, underrun} !== 2'b00) begin
            n_err++; $display("FAIL reset_ready_underrun got=%b exp=00", {s_ready, underrun});
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if (s_ready !== 1'b1) begin
            n_err++; $display("FAIL post_reset_ready got=%b exp=1", s_ready);
        end
    endtask

    task automatic test_idle();
        logic [76:0] exp;
        exp = {F_IDLE, 8'h00, 64'h0};
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if (blk !== exp) begin
                n_err++; $display("FAIL idle_blk[%0d] got=%h exp=%h", i, blk, exp);
            end
        end
    endtask

    task automatic drain_ipg(input string name);
        for (int i = 0; i < int'(IPG_BLK); i++) begin
            n_cmp++;
            if (s_ready !== 1'b0) begin
                n_err++; $display("FAIL %s_ipg_ready[%0d] got=%b exp=0", name, i, s_ready);
            end
            tick();
            n_cmp++;
            if (blk !== {F_IDLE, 8'h00, 64'h0}) begin
                n_err++; $display("FAIL %s_ipg_idle[%0d] got=%h", name, i, blk);
            end
        end
        n_cmp++;
        if (s_ready !== 1'b1) begin
            n_err++; $display("FAIL %s_ipg_ready_end got=%b exp=1", name, s_ready);
        end
    endtask

    task automatic test_three_beat();
        logic [76:0] exp;
        beat(64'hD555555555555555, 8'hFF, 1'b0);
        tick();
        exp = {F_START, 8'hFF, 64'hD555555555555555};
        n_cmp++;
        if (blk !== exp) begin
            n_err++; $display("FAIL tb_start got=%h exp=%h", blk, exp);
        end
        beat(64'h0123456789ABCDEF, 8'hFF, 1'b0);
        tick();
        exp = {F_DATA, 8'hFF, 64'h0123456789ABCDEF};
        n_cmp++;
        if (blk !== exp) begin
            n_err++; $display("FAIL tb_data got=%h exp=%h", blk, exp);
        end
        beat(64'h1111111111CCBBAA, 8'h07, 1'b1);
        tick();
        s_valid = 1'b0;
        exp = {F_TERM, 8'h07, 64'h00000000CCBBAA00};
        n_cmp++;
        if (blk !== exp) begin
            n_err++; $display("FAIL tb_term got=%h exp=%h", blk, exp);
        end
        drain_ipg("tb");
    endtask

    task automatic test_keep_ff();
        logic [76:0] exp;
        beat(64'hA5A5A5A5A5A5A5A5, 8'hFF, 1'b0);
        tick();
        beat(64'hFEDCBA9876543210, 8'hFF, 1'b1);
        tick();
        s_valid = 1'b0;
        exp = {F_DATA, 8'hFF, 64'hFEDCBA9876543210};
        n_cmp++;
        if (blk !== exp) begin
            n_err++; $display("FAIL ff_last_data got=%h exp=%h", blk, exp);
        end
        n_cmp++;
        if (s_ready !== 1'b0) begin
            n_err++; $display("FAIL ff_term0_ready got=%b exp=0", s_ready);
        end
        tick();
        exp = {F_TERM, 8'h00, 64'h0};
        n_cmp++;
        if (blk !== exp) begin
            n_err++; $display("FAIL ff_term0 got=%h exp=%h", blk, exp);
        end
        drain_ipg("ff");
    endtask

    task automatic test_underrun();
        logic [76:0] exp;
        int idles;
        bit got_start;
        beat(64'h5555555555555555, 8'hFF, 1'b0);
        tick();
        s_valid = 1'b0;
        tick();
        exp = {F_ERR, 8'h00, 64'h0};
        n_cmp++;
        if (blk !== exp) begin
            n_err++; $display("FAIL ur_term got=%h exp=%h", blk, exp);
        end
        n_cmp++;
        if (underrun !== 1'b1) begin
            n_err++; $display("FAIL ur_pulse_hi got=%b exp=1", underrun);
        end
        beat(64'h0000000000C0FFEE, 8'hFF, 1'b0);
        idles = 0;
        got_start = 1'b0;
        for (int i = 0; i < 10 && !got_start; i++) begin
            tick();
            if (i == 0) begin
                n_cmp++;
                if (underrun !== 1'b0) begin
                    n_err++; $display("FAIL ur_pulse_lo got=%b exp=0", underrun);
                end
            end
            if (start_v === 1'b1) got_start = 1'b1;
            else if (idle_v === 1'b1) idles++;
        end
        n_cmp++;
        if (!got_start || idles != int'(IPG_BLK)) begin
            n_err++; $display("FAIL ur_gap idles=%0d started=%0d exp=%0d/1", idles, got_start, IPG_BLK);
        end
        beat(64'h00000000000000AB, 8'h01, 1'b1);
        tick();
        s_valid = 1'b0;
        exp = {F_TERM, 8'h01, 64'h000000000000AB00};
        n_cmp++;
        if (blk !== exp) begin
            n_err++; $display("FAIL ur_next_term got=%h exp=%h", blk, exp);
        end
        drain_ipg("ur");
    endtask

    task automatic test_stall();
        logic [76:0] exp;
        beat(64'h1000000000000001, 8'hFF, 1'b0);
        tick();
        beat(64'h2000000000000002, 8'hFF, 1'b0);
        gb_ready = 1'b0;
        #1;
        n_cmp++;
        if (s_ready !== 1'b0) begin
            n_err++; $display("FAIL st_ready_stall got=%b exp=0", s_ready);
        end
        tick();
        exp = {F_START, 8'hFF, 64'h1000000000000001};
        n_cmp++;
        if (blk !== exp) begin
            n_err++; $display("FAIL st_hold_start got=%h exp=%h", blk, exp);
        end
        gb_ready = 1'b1;
        tick();
        exp = {F_DATA, 8'hFF, 64'h2000000000000002};
        n_cmp++;
        if (blk !== exp) begin
            n_err++; $display("FAIL st_data got=%h exp=%h", blk, exp);
        end
        beat(64'h8877665544332211, 8'h3F, 1'b1);
        gb_ready = 1'b0;
        tick();
        n_cmp++;
        if (blk !== exp) begin
            n_err++; $display("FAIL st_hold_data got=%h exp=%h", blk, exp);
        end
        gb_ready = 1'b1;
        tick();
        exp = {F_TERM, 8'h3F, 64'h0066554433221100};
        n_cmp++;
        if (blk !== exp) begin
            n_err++; $display("FAIL st_term got=%h exp=%h", blk, exp);
        end
        beat(64'h3000000000000003, 8'hFF, 1'b0);
        for (int c = 1; c <= int'(IPG_BLK) + 1; c++) begin
            gb_ready = 1'b0;
            tick();
            n_cmp++;
            if (blk !== exp || s_ready !== 1'b0) begin
                n_err++; $display("FAIL st_ipg_hold[%0d] got=%h rdy=%b exp=%h", c, blk, s_ready, exp);
            end
            gb_ready = 1'b1;
            tick();
            exp = (c <= int'(IPG_BLK)) ? {F_IDLE, 8'h00, 64'h0}
                                       : {F_START, 8'hFF, 64'h3000000000000003};
            n_cmp++;
            if (blk !== exp) begin
                n_err++; $display("FAIL st_ipg_blk[%0d] got=%h exp=%h", c, blk, exp);
            end
        end
        beat(64'h4000000000000004, 8'hFF, 1'b1);
        tick();
        s_valid = 1'b0;
        exp = {F_DATA, 8'hFF, 64'h4000000000000004};
        n_cmp++;
        if (blk !== exp) begin
            n_err++; $display("FAIL st_last_data got=%h exp=%h", blk, exp);
        end
        tick();
        drain_ipg("st");
    endtask

    task automatic test_reset_mid();
        logic [76:0] exp;
        beat(64'h7777777777777777, 8'hFF, 1'b0);
        tick();
        beat(64'h6666666666666666, 8'hFF, 1'b0);
        tick();
        reset = 1'b1;
        s_valid = 1'b0;
        tick();
        exp = {F_IDLE, 8'h00, 64'h0};
        n_cmp++;
        if (blk !== exp) begin
            n_err++; $display("FAIL rm_idle got=%h exp=%h", blk, exp);
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if (s_ready !== 1'b1) begin
            n_err++; $display("FAIL rm_ready got=%b exp=1", s_ready);
        end
        beat(64'hD555555555555555, 8'hFF, 1'b0);
        tick();
        exp = {F_START, 8'hFF, 64'hD555555555555555};
        n_cmp++;
        if (blk !== exp) begin
            n_err++; $display("FAIL rm_start got=%h exp=%h", blk, exp);
        end
        beat(64'hFFFFFFFFDDCCBBAA, 8'h0F, 1'b1);
        tick();
        s_valid = 1'b0;
        exp = {F_TERM, 8'h0F, 64'h000000DDCCBBAA00};
        n_cmp++;
        if (blk !== exp) begin
            n_err++; $display("FAIL rm_term got=%h exp=%h", blk, exp);
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_three_beat();
        test_keep_ff();
        test_underrun();
        test_stall();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
